// File: rtl/trap_ctrl.sv
// trap_ctrl: writeback-stage trap controller arbitrating exceptions, xRET and timer interrupt ahead of the CSR file
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   wb_valid_i, wb_pc_i    instruction in WB and its PC
//   illegal_i .. sret_i    decode flags of the WB instruction
//   priv_i, mie_i          current privilege and mstatus.MIE from the CSR file
//   timer_irq_i            machine timer interrupt level
//   newpc_i                trap/return target from the CSR file
//   exception_o, cause_o, pc_o   one-cycle registered trap request to the CSR file
//   flush_o                kill younger stages while a trap is in flight
//   redirect_valid_o, redirect_pc_o, redirect_ready_i   valid/ready redirect to IF
//   instret_o              retired-instruction count (minstret)
module trap_ctrl #(
  parameter logic [63:0] IRQ_CAUSE = {1'b1, 63'd7}
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid_i,
  input  logic [63:0] wb_pc_i,
  input  logic        illegal_i,
  input  logic        ebreak_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        sret_i,
  input  logic [1:0]  priv_i,
  input  logic        mie_i,
  input  logic        timer_irq_i,
  input  logic [63:0] newpc_i,
  output logic        exception_o,
  output logic [63:0] cause_o,
  output logic [63:0] pc_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic [63:0] instret_o
);
  // Cause codes shared with the CSR file (define.v); xRET use codes above the architectural range
  localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
  localparam logic [63:0] CAUSE_EBREAK  = 64'd3;
  localparam logic [63:0] ECALL_FROM_U  = 64'd8;
  localparam logic [63:0] ECALL_FROM_S  = 64'd9;
  localparam logic [63:0] ECALL_FROM_M  = 64'd11;
  localparam logic [63:0] MRET          = 64'h10;
  localparam logic [63:0] SRET          = 64'h11;
  typedef enum logic [1:0] {IDLE, TRAP, REDIRECT} state_t;
  state_t      state;
  logic        irq_pending;
  logic        irq_now;
  logic        irq_take;
  logic        ev_hit;
  logic [63:0] ecall_cause;
  logic [63:0] ev_cause;
  // A request arriving on the same edge counts as pending, so set-and-take leaves the flag clear
  always_comb begin
    irq_now     = irq_pending | timer_irq_i;
    irq_take    = (state == IDLE) && wb_valid_i && irq_now && mie_i;
    ev_hit      = irq_take || ((state == IDLE) && wb_valid_i &&
                  (illegal_i || ebreak_i || ecall_i || mret_i || sret_i));
    ecall_cause = (priv_i == 2'b00) ? ECALL_FROM_U :
                  (priv_i == 2'b01) ? ECALL_FROM_S : ECALL_FROM_M;
    ev_cause    = irq_take  ? IRQ_CAUSE     :
                  illegal_i ? CAUSE_ILLEGAL :
                  ebreak_i  ? CAUSE_EBREAK  :
                  ecall_i   ? ecall_cause   :
                  mret_i    ? MRET          : SRET;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      irq_pending      <= 1'b0;
      exception_o      <= 1'b0;
      cause_o          <= '0;
      pc_o             <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      instret_o        <= '0;
    end else begin
      irq_pending <= irq_now && !irq_take;
      case (state)
        IDLE: begin
          if (ev_hit) begin
            cause_o     <= ev_cause;
            pc_o        <= wb_pc_i;
            exception_o <= 1'b1;
            flush_o     <= 1'b1;
            state       <= TRAP;
          end else if (wb_valid_i) begin
            instret_o   <= instret_o + 64'd1;
          end
        end
        TRAP: begin
          exception_o      <= 1'b0;
          redirect_pc_o    <= newpc_i;
          redirect_valid_o <= 1'b1;
          state            <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
  localparam logic [63:0] IRQ = {1'b1, 63'd7};
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [63:0] wb_pc_i = '0;
  logic        illegal_i = 1'b0, ebreak_i = 1'b0, ecall_i = 1'b0, mret_i = 1'b0, sret_i = 1'b0;
  logic [1:0]  priv_i = 2'b00;
  logic        mie_i = 1'b0;
  logic        timer_irq_i = 1'b0;
  logic [63:0] newpc_i = '0;
  logic        exception_o;
  logic [63:0] cause_o;
  logic [63:0] pc_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i = 1'b1;
  logic [63:0] instret_o;
  int tests = 0;
  int failed = 0;
  trap_ctrl #(.IRQ_CAUSE(IRQ)) dut (
    .clock(clock), .reset_n(reset_n), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .illegal_i(illegal_i), .ebreak_i(ebreak_i), .ecall_i(ecall_i), .mret_i(mret_i), .sret_i(sret_i),
    .priv_i(priv_i), .mie_i(mie_i), .timer_irq_i(timer_irq_i), .newpc_i(newpc_i),
    .exception_o(exception_o), .cause_o(cause_o), .pc_o(pc_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .instret_o(instret_o)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic clear_flags;
    wb_valid_i = 1'b0; illegal_i = 1'b0; ebreak_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; sret_i = 1'b0;
    timer_irq_i = 1'b0;
  endtask
  // Inputs already set up; checks the trap request, then drains TRAP and REDIRECT with ready high.
  task automatic expect_trap(input string tag, input logic [63:0] exp_cause, input logic [63:0] exp_pc);
    step;
    chk({tag, "_exc"}, {63'd0, exception_o}, 64'd1);
    chk({tag, "_cause"}, cause_o, exp_cause);
    chk({tag, "_pc"}, pc_o, exp_pc);
    clear_flags;
    step;
    chk({tag, "_rdv"}, {63'd0, redirect_valid_o}, 64'd1);
    step;
    chk({tag, "_idle"}, {63'd0, redirect_valid_o}, 64'd0);
  endtask
  initial begin
    #2;
    chk("rst_exc", {63'd0, exception_o}, 64'd0);
    chk("rst_flush", {63'd0, flush_o}, 64'd0);
    chk("rst_rdv", {63'd0, redirect_valid_o}, 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_cause", cause_o, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wb_valid_i = 1'b1;
    wb_pc_i = 64'h100;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("ret_exc", {63'd0, exception_o}, 64'd0);
    end
    chk("ret_instret", instret_o, 64'd5);
    wb_pc_i = 64'h8000_0010; newpc_i = 64'h8000_0200; ecall_i = 1'b1; priv_i = 2'b00;
    step;
    chk("ecu_exc", {63'd0, exception_o}, 64'd1);
    chk("ecu_cause", cause_o, 64'd8);
    chk("ecu_pc", pc_o, 64'h8000_0010);
    chk("ecu_flush", {63'd0, flush_o}, 64'd1);
    chk("ecu_rdv0", {63'd0, redirect_valid_o}, 64'd0);
    clear_flags;
    step;
    chk("ecu_exc_drop", {63'd0, exception_o}, 64'd0);
    chk("ecu_rdv", {63'd0, redirect_valid_o}, 64'd1);
    chk("ecu_rpc", redirect_pc_o, 64'h8000_0200);
    chk("ecu_flush2", {63'd0, flush_o}, 64'd1);
    step;
    chk("ecu_rdv_done", {63'd0, redirect_valid_o}, 64'd0);
    chk("ecu_flush_done", {63'd0, flush_o}, 64'd0);
    chk("ecu_instret", instret_o, 64'd5);
    redirect_ready_i = 1'b0;
    wb_valid_i = 1'b1; mret_i = 1'b1; wb_pc_i = 64'h1000; newpc_i = 64'h2000;
    step;
    chk("bp_exc", {63'd0, exception_o}, 64'd1);
    chk("bp_cause", cause_o, 64'h10);
    clear_flags;
    step;
    chk("bp_rpc0", redirect_pc_o, 64'h2000);
    newpc_i = 64'hdead; wb_valid_i = 1'b1; illegal_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("bp_rdv", {63'd0, redirect_valid_o}, 64'd1);
      chk("bp_flush", {63'd0, flush_o}, 64'd1);
      chk("bp_rpc", redirect_pc_o, 64'h2000);
      chk("bp_exc_hold", {63'd0, exception_o}, 64'd0);
    end
    clear_flags;
    redirect_ready_i = 1'b1;
    step;
    chk("bp_rdv_done", {63'd0, redirect_valid_o}, 64'd0);
    chk("bp_flush_done", {63'd0, flush_o}, 64'd0);
    chk("bp_instret", instret_o, 64'd5);
    mie_i = 1'b0; timer_irq_i = 1'b1; wb_valid_i = 1'b1; wb_pc_i = 64'h3000;
    step;
    chk("irq_masked_exc", {63'd0, exception_o}, 64'd0);
    chk("irq_masked_instret", instret_o, 64'd6);
    chk("irq_pend_set", {63'd0, dut.irq_pending}, 64'd1);
    clear_flags;
    step;
    chk("irq_pend_hold", {63'd0, dut.irq_pending}, 64'd1);
    chk("irq_idle_exc", {63'd0, exception_o}, 64'd0);
    mie_i = 1'b1; wb_valid_i = 1'b1; illegal_i = 1'b1; wb_pc_i = 64'h4000; newpc_i = 64'h5000;
    step;
    chk("irq_exc", {63'd0, exception_o}, 64'd1);
    chk("irq_cause", cause_o, IRQ);
    chk("irq_pc", pc_o, 64'h4000);
    chk("irq_pend_clr", {63'd0, dut.irq_pending}, 64'd0);
    clear_flags;
    step;
    step;
    chk("irq_done", {63'd0, redirect_valid_o}, 64'd0);
    timer_irq_i = 1'b1;
    step;
    chk("irq_nowb_exc", {63'd0, exception_o}, 64'd0);
    chk("irq_nowb_pend", {63'd0, dut.irq_pending}, 64'd1);
    timer_irq_i = 1'b0; wb_valid_i = 1'b1; wb_pc_i = 64'h6000;
    expect_trap("irq_late", IRQ, 64'h6000);
    wb_valid_i = 1'b1; timer_irq_i = 1'b1; illegal_i = 1'b1; wb_pc_i = 64'h6100;
    expect_trap("irq_same_edge", IRQ, 64'h6100);
    chk("irq_same_edge_pend", {63'd0, dut.irq_pending}, 64'd0);
    mie_i = 1'b0;
    wb_valid_i = 1'b1; illegal_i = 1'b1; ebreak_i = 1'b1; ecall_i = 1'b1; wb_pc_i = 64'h6200;
    expect_trap("prio_ill", 64'd2, 64'h6200);
    wb_valid_i = 1'b1; ebreak_i = 1'b1; ecall_i = 1'b1; wb_pc_i = 64'h6300;
    expect_trap("prio_ebreak", 64'd3, 64'h6300);
    wb_valid_i = 1'b1; ecall_i = 1'b1; priv_i = 2'b01; wb_pc_i = 64'h6400;
    expect_trap("ecall_s", 64'd9, 64'h6400);
    wb_valid_i = 1'b1; ecall_i = 1'b1; priv_i = 2'b11; wb_pc_i = 64'h6500;
    expect_trap("ecall_m", 64'd11, 64'h6500);
    wb_valid_i = 1'b1; mret_i = 1'b1; sret_i = 1'b1; wb_pc_i = 64'h6600;
    expect_trap("prio_mret", 64'h10, 64'h6600);
    wb_valid_i = 1'b1; sret_i = 1'b1; wb_pc_i = 64'h6700;
    expect_trap("sret", 64'h11, 64'h6700);
    chk("trap_instret", instret_o, 64'd6);
    redirect_ready_i = 1'b0;
    wb_valid_i = 1'b1; ebreak_i = 1'b1; wb_pc_i = 64'h7000; newpc_i = 64'h7100;
    step;
    clear_flags;
    step;
    chk("mid_rdv", {63'd0, redirect_valid_o}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdv", {63'd0, redirect_valid_o}, 64'd0);
    chk("mid_rst_flush", {63'd0, flush_o}, 64'd0);
    chk("mid_rst_instret", instret_o, 64'd0);
    chk("mid_rst_rpc", redirect_pc_o, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    redirect_ready_i = 1'b1;
    wb_valid_i = 1'b1; wb_pc_i = 64'h8000;
    step;
    chk("post_rst_instret", instret_o, 64'd1);
    chk("post_rst_exc", {63'd0, exception_o}, 64'd0);
    clear_flags;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Writeback-stage trap controller sitting directly upstream of the CSR file. It arbitrates synchronous exceptions, xRET and the machine timer interrupt for the instruction in WB. It drives a registered one-cycle trap request (`exception`, `cause`, `pc`) into the CSR file and captures the CSR file's returned target PC. It then holds a valid/ready redirect to IF while flushing the pipeline, and counts retired instructions for `minstret`.

## Interface
Parameters:
- `IRQ_CAUSE`, default `{1'b1, 63'd7}`: cause value driven for a machine timer interrupt.

Ports:
- `clock`  in  1  Sole clock; all state updates on the rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `wb_valid_i`  in  1  WB holds a valid instruction this cycle.
- `wb_pc_i`  in  64  PC of the WB instruction.
- `illegal_i`, `ebreak_i`, `ecall_i`, `mret_i`, `sret_i`  in  1 each  Decode flags of the WB instruction.
- `priv_i`  in  2  Current privilege from the CSR file.
- `mie_i`  in  1  `mstatus.MIE` from the CSR file.
- `timer_irq_i`  in  1  Timer interrupt request level.
- `newpc_i`  in  64  Trap or return target from the CSR file (`exception_newPC`).
- `exception_o`  out  1  Trap request to the CSR file, one cycle wide.
- `cause_o`  out  64  Cause to the CSR file.
- `pc_o`  out  64  Faulting or return PC to the CSR file.
- `flush_o`  out  1  Kill all younger pipeline stages.
- `redirect_valid_o`  out  1  Redirect request to IF.
- `redirect_pc_o`  out  64  Redirect target.
- `redirect_ready_i`  in  1  IF accepts the redirect.
- `instret_o`  out  64  Retired-instruction count.

## Operation
- States are IDLE, TRAP and REDIRECT, with state bits encoded in 2 bits.
- **IDLE.** At each edge with `wb_valid_i`=1 the event is chosen by fixed priority:
  1. Interrupt: `irq_pending` && `mie_i`. Cause is `IRQ_CAUSE`.
  2. `illegal_i`: cause 2.
  3. `ebreak_i`: cause 3.
  4. `ecall_i`: cause is `ECALL_FROM_U`, `ECALL_FROM_S` or `ECALL_FROM_M` (define.v), selected by `priv_i`.
  5. `mret_i`: cause `MRET`.
  6. `sret_i`: cause `SRET`.
- **IDLE, event found.** Register `cause_o` and `pc_o` = `wb_pc_i`, set `exception_o`=1, go to TRAP. The instruction does not retire.
- **IDLE, no event.** Increment `instret_o` by 1 (wraps modulo 2^64) and stay in IDLE.
- **TRAP**, exactly one cycle:
  - `exception_o`=1 and `flush_o`=1.
  - At the closing edge: capture `newpc_i` into `redirect_pc_o`, clear `exception_o`, set `redirect_valid_o`, go to REDIRECT.
- **REDIRECT:**
  - `flush_o`=1; `redirect_valid_o` and `redirect_pc_o` are held stable.
  - At the edge with `redirect_ready_i`=1: clear `redirect_valid_o` and `flush_o`, go to IDLE.
- **`irq_pending` flag:**
  - Set at any edge where `timer_irq_i`=1.
  - Cleared at the edge where the interrupt is taken.
  - Set and take in the same edge leaves it cleared.
  - Never cleared by `mie_i`=0; the interrupt waits.
- **Outside IDLE:** `wb_valid_i` and the decode flags are ignored. No retire and no new trap, because those instructions are flushed.
- **Illegal flag combinations** (several flags set) are resolved by priority only. No error is signalled.

## Timing
- **Reset values** (asynchronous, on `reset_n`=0): state IDLE; `exception_o`, `flush_o` and `redirect_valid_o` = 0; `cause_o`, `pc_o`, `redirect_pc_o` and `instret_o` = 0; `irq_pending` = 0.
- **Trap latency.** Event sampled at edge N gives `exception_o`=1 during cycle N→N+1 only. `redirect_valid_o`=1 from edge N+1. The earliest return to IDLE is edge N+2, with ready already high.
- **Back-to-back.** The earliest subsequent event is sampled at the edge after the handshake edge.
- **`newpc_i`** must be valid combinationally while `exception_o`=1. It is sampled only at the TRAP-exit edge.
- **Mid-operation reset.** Asserting `reset_n` in TRAP or REDIRECT aborts immediately and all outputs drop. `instret_o` returns to 0.
- **Simultaneous interrupt and exception.** When `timer_irq_i` is high with a synchronous exception, the interrupt wins. `pc_o` is still `wb_pc_i`.
- **Interrupt with no instruction.** `irq_pending` && `mie_i` with `wb_valid_i`=0 takes nothing and keeps the flag pending.

## Test plan
- **Plain retirement.** Reset, then 5 cycles of `wb_valid_i`=1 with no flags → `instret_o`=5, `exception_o` never asserted.
- **ECALL from U.** `ecall_i`=1, `priv_i`=U, `wb_pc_i`=0x8000_0010 at edge N, `newpc_i`=0x8000_0200, `redirect_ready_i`=1 → `exception_o` high for one cycle with cause `ECALL_FROM_U` and `pc_o`=0x8000_0010. Then `redirect_pc_o`=0x8000_0200, valid for one cycle, back in IDLE at N+2. `instret_o` unchanged.
- **Redirect backpressure.** Raise `mret_i` with `redirect_ready_i` held 0 for 4 cycles → `redirect_valid_o` and `flush_o` stay high with a constant PC. Wrong-path `wb_valid_i` and `illegal_i` pulses are ignored. The handshake completes at the first ready edge.
- **Interrupt priority and pending.**
  - Pulse `timer_irq_i` for 1 cycle while `mie_i`=0 → no trap and `irq_pending` stays 1.
  - Set `mie_i`=1 with `wb_valid_i`=1 and `illegal_i`=1 → cause `IRQ_CAUSE` (not 2), `pc_o`=`wb_pc_i`, `irq_pending` cleared.
- **Priority.** `illegal_i`, `ebreak_i` and `ecall_i` all high → cause 2.
- **Reset mid-REDIRECT.** Assert `reset_n`=0 asynchronously between edges → `redirect_valid_o`, `flush_o` and `instret_o` go to 0 immediately. After release, a plain instruction gives `instret_o`=1.
